// File: rtl/stack_if.sv
// stack_if: push/pop request and status bundle for stack_unit; STACK_NOS_EN adds nos.
interface stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    logic push;
    logic pop;
    logic clear_err;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] tos;
    logic [$clog2(DEPTH):0] count;
    logic empty;
    logic full;
    logic overflow;
    logic underflow;
`ifdef STACK_NOS_EN
    logic [WIDTH-1:0] nos;
`endif
    modport master (
`ifdef STACK_NOS_EN
        input nos,
`endif
        output push, pop, din, clear_err,
        input tos, count, empty, full, overflow, underflow
    );
    modport slave (
`ifdef STACK_NOS_EN
        output nos,
`endif
        input push, pop, din, clear_err,
        output tos, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/stack_unit.sv
// stack_unit: single-cycle push/pop/replace stack with sticky error flags.
// Optional STACK_NOS_EN adds a registered next-on-stack output (bus.nos).
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input logic clk,
    input logic reset,
    stack_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0] count, count_nxt;
    logic [AW-1:0] ptr;
    logic [WIDTH-1:0] tos;
    logic empty, full, overflow, underflow;
    logic wr_push, rd_pop, rep, ovf_evt, udf_evt;
    // push+pop on an empty stack degrades to a plain push
    always_comb begin
        ptr       = count[AW-1:0];
        wr_push   = bus.push && (!bus.pop || empty) && !full;
        ovf_evt   = bus.push && !bus.pop && full;
        rep       = bus.push && bus.pop && !empty;
        rd_pop    = bus.pop && !bus.push && !empty;
        udf_evt   = bus.pop && !bus.push && empty;
        count_nxt = count + CW'(wr_push) - CW'(rd_pop);
    end
    always_ff @(posedge clk) begin
        if (wr_push)
            mem[ptr] <= bus.din;
        else if (rep)
            mem[ptr - AW'(1)] <= bus.din;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            tos       <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_nxt;
            empty     <= count_nxt == '0;
            full      <= count_nxt == CW'(DEPTH);
            overflow  <= (overflow && !bus.clear_err) || ovf_evt;
            underflow <= (underflow && !bus.clear_err) || udf_evt;
            if (wr_push || rep)
                tos <= bus.din;
            else if (rd_pop)
                tos <= count > CW'(1) ? mem[ptr - AW'(2)] : '0;
        end
    end
`ifdef STACK_NOS_EN
    logic [WIDTH-1:0] nos;
    always_ff @(posedge clk) begin
        if (reset)
            nos <= '0;
        else if (wr_push)
            nos <= tos;
        else if (rd_pop)
            nos <= count > CW'(2) ? mem[ptr - AW'(3)] : '0;
    end
    assign bus.nos = nos;
`endif
    assign bus.tos       = tos;
    assign bus.count     = count;
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.overflow  = overflow;
    assign bus.underflow = underflow;
endmodule
